unary_add_sequencer: RTL

//  Drives one serial unary adder. Takes a pair of binary operands over a valid/ready handshake
//  and streams them into the adder as thermometer bitstreams. It then switches the adder to

---
 rtl/unary_add_pkg.sv | 27 ++
 rtl/unary_stream_gen.sv | 20 ++
 rtl/unary_add_sequencer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/unary_add_pkg.sv
// rtl/unary_add_pkg.sv - shared types and width helpers for the unary adder sequencer
// Purpose: sequencer state encoding, default stream length and width helpers.
// Ports: none (package).
package unary_add_pkg;

  localparam int LEN_DEFAULT = 14;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_STREAM,
    ST_SWITCH,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Operand width: must hold 0..len.
  function automatic int width_w(input int len);
    return $clog2(len + 1);
  endfunction

  // Sum width: must hold 0..2*len.
  function automatic int width_cw(input int len);
    return $clog2(2 * len + 1);
  endfunction

endpackage

// File: rtl/unary_stream_gen.sv
// rtl/unary_stream_gen.sv - binary value to thermometer bit for one stream cycle
// Purpose: emits 1 while the cycle index is below the value, so a value v
//          produces exactly v leading ones over the stream.
// Ports:
//   value   in  W  binary operand (already clamped)
//   index   in  W  current stream cycle index
//   bit_out out 1  thermometer bit for this cycle
module unary_stream_gen
  import unary_add_pkg::*;
#(
  parameter int W = width_w(LEN_DEFAULT)
) (
  input  logic [W-1:0] value,
  input  logic [W-1:0] index,
  output logic         bit_out
);

  assign bit_out = (index < value);

endmodule

// File: rtl/unary_add_sequencer.sv
// rtl/unary_add_sequencer.sv - feeds one serial unary adder and collects its binary sum
// Purpose: accepts an operand pair, streams both as thermometer codes into the
//          adder, switches it to write mode, counts its output ones and returns
//          the sum with overflow and self-check flags.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      operand handshake; a_val, b_val binary operands
//   out_valid/out_ready    result handshake; sum, ovf, err result fields
//   add_rst_n, add_en      adder reset (active-low) and enable
//   add_rw                 adder mode: 0 read operands, 1 write result
//   add_A, add_B           unary operand streams
//   add_dout, add_C        adder serial result and carry/overflow
module unary_add_sequencer
  import unary_add_pkg::*;
#(
  parameter int LEN   = LEN_DEFAULT,
  parameter int W     = width_w(LEN),
  parameter int CW    = width_cw(LEN),
  parameter int DRAIN = 2 * LEN
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a_val,
  input  logic [W-1:0]  b_val,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] sum,
  output logic          ovf,
  output logic          err,
  output logic          add_rst_n,
  output logic          add_en,
  output logic          add_rw,
  output logic          add_A,
  output logic          add_B,
  input  logic          add_dout,
  input  logic          add_C
);

  // One counter serves both the stream phase and the drain window.
  localparam int CNTW = $clog2(DRAIN + 1);

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [W-1:0]    a_clamp, b_clamp;
  logic [CW-1:0]   sum_d;
  logic            ovf_d, err_d;
  logic            in_ready_d, out_valid_d;
  logic            add_rst_n_d, add_en_d, add_rw_d, add_a_d, add_b_d;
  logic            therm_a, therm_b;

  assign a_clamp = (a_val > W'(LEN)) ? W'(LEN) : a_val;
  assign b_clamp = (b_val > W'(LEN)) ? W'(LEN) : b_val;

  // Stream bits are generated for the index the counter is about to hold,
  // so the registered add_A/add_B line up with the registered state.
  unary_stream_gen #(.W(W)) u_gen_a (
    .value   (a_q),
    .index   (cnt_d[W-1:0]),
    .bit_out (therm_a)
  );

  unary_stream_gen #(.W(W)) u_gen_b (
    .value   (b_q),
    .index   (cnt_d[W-1:0]),
    .bit_out (therm_b)
  );

  // Next state, counter and result fields.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum;
    ovf_d   = ovf;
    err_d   = err;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a_clamp;
          b_d     = b_clamp;
          cnt_d   = '0;
          sum_d   = '0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        cnt_d   = '0;
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        // Counter holds LEN-1 on exit; SWITCH restarts it.
        if (cnt_q == CNTW'(LEN - 1)) begin
          state_d = ST_SWITCH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SWITCH: begin
        cnt_d   = '0;
        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (sum != CW'(2 * LEN)) begin
          sum_d = sum + CW'(add_dout);
        end
        ovf_d = ovf | add_C;
        if (cnt_q == CNTW'(DRAIN - 1)) begin
          err_d   = (sum_d != (CW'(a_q) + CW'(b_q)));
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output values for the state being entered; registered below.
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    add_rst_n_d = 1'b1;
    add_en_d    = 1'b0;
    add_rw_d    = 1'b0;
    add_a_d     = 1'b0;
    add_b_d     = 1'b0;
    case (state_d)
      ST_IDLE:   in_ready_d = 1'b1;
      ST_CLEAR:  add_rst_n_d = 1'b0;
      ST_STREAM: begin
        add_en_d = 1'b1;
        add_a_d  = therm_a;
        add_b_d  = therm_b;
      end
      ST_SWITCH, ST_DRAIN: begin
        add_en_d = 1'b1;
        add_rw_d = 1'b1;
      end
      ST_DONE:   out_valid_d = 1'b1;
      default:   in_ready_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      ovf       <= 1'b0;
      err       <= 1'b0;
      add_rst_n <= 1'b0;
      add_en    <= 1'b0;
      add_rw    <= 1'b0;
      add_A     <= 1'b0;
      add_B     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      sum       <= sum_d;
      ovf       <= ovf_d;
      err       <= err_d;
      add_rst_n <= add_rst_n_d;
      add_en    <= add_en_d;
      add_rw    <= add_rw_d;
      add_A     <= add_a_d;
      add_B     <= add_b_d;
    end
  end

endmodule
